// File: rtl/display_ram_arbiter.sv
// Arbitrates the board display RAM read port between the LED scanner (absolute priority) and game logic.
// Optional DISPLAY_ARB_CONFLICT_CNT_EN adds a saturating count of cycles where a waiting game read was denied.
module display_ram_arbiter #(
  parameter int SCAN_LEN = 8,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic              scan_grant,
  input  logic              game_req,
  input  logic [ADDR_W-1:0] game_addr,
  output logic              game_ack,
  output logic [1:0]        game_data,
  output logic [ADDR_W-1:0] ram_rd_addr,
`ifdef DISPLAY_ARB_CONFLICT_CNT_EN
  input  logic              conflict_clr,
  output logic [7:0]        conflict_cnt,
`endif
  input  logic [1:0]        ram_data
);
  localparam int CW = $clog2(SCAN_LEN) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, ACK} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          game_ack_q;
  logic [1:0]    game_data_q;
  logic          game_gnt;

  assign scan_grant = scan_req | (state_q == SCAN);
  // scan_req is excluded explicitly so the scanner never loses its first beat
  assign game_gnt   = (state_q == IDLE) && game_req && !scan_req;
  assign game_ack   = game_ack_q;
  assign game_data  = game_data_q;

  always_comb begin
    ram_rd_addr = '0;
    if (scan_grant)    ram_rd_addr = scan_addr;
    else if (game_gnt) ram_rd_addr = game_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      game_ack_q  <= 1'b0;
      game_data_q <= 2'b00;
    end else begin
      game_ack_q <= game_gnt;
      if (game_gnt) game_data_q <= ram_data;
      if (scan_req) begin
        // a new pulse (re)starts the burst, even mid-burst
        cnt_q   <= CW'(1);
        state_q <= (SCAN_LEN > 1) ? SCAN : IDLE;
      end else begin
        case (state_q)
          IDLE: if (game_gnt) state_q <= ACK;
          ACK:  state_q <= IDLE;
          SCAN: begin
            if (cnt_q == CW'(SCAN_LEN - 1)) state_q <= IDLE;
            else cnt_q <= cnt_q + CW'(1);
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef DISPLAY_ARB_CONFLICT_CNT_EN
  logic [7:0] conflict_q;
  assign conflict_cnt = conflict_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               conflict_q <= 8'd0;
    else if (conflict_clr) conflict_q <= 8'd0;
    else if (game_req && state_q != ACK && scan_grant && conflict_q != 8'hFF)
      conflict_q <= conflict_q + 8'd1;
  end
`endif
endmodule
